ssd1306_i2c_target: RTL and testbench

Emulates the write side of an SSD1306 display as an I²C target at a fixed 7-bit address. Decodes the control byte, command stream (addressing commands plus argument skipping) and GDDRAM data, and emits one-cycle framebuffer write strobes in {page, column} address form. Sits on the same open-drain SDA/SCL pair as `ssd1306_controller` (in loopback benches or an FPGA-hosted display model) and feeds a 1024×8 framebuffer RAM.

---
 rtl/ssd1306_i2c_target.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_ssd1306_i2c_target.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_i2c_target.sv
// ssd1306_i2c_target: write-only SSD1306 display emulation as an I2C target.
// Decodes the control byte, addressing commands (with argument skipping) and
// GDDRAM data, and emits one-cycle framebuffer write strobes at {page, column}.

module ssd1306_i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_e,
  output logic       fb_wr_ena,
  output logic [9:0] fb_wr_addr,
  output logic [7:0] fb_wr_data,
  output logic       cmd_strobe,
  output logic [7:0] cmd_byte,
  output logic       display_on,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_CTRL     = 3'd3,
    S_CTRL_ACK = 3'd4,
    S_BYTE     = 3'd5,
    S_BYTE_ACK = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  localparam logic [1:0] MODE_HORZ = 2'b00;
  localparam logic [1:0] MODE_VERT = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  // Pin synchronizers and previous-value registers
  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic                   scl_prev_r, sda_prev_r;
  logic                   scl_s, sda_s;
  logic                   scl_rise_s, scl_fall_s, start_s, stop_s;

  // FSM and datapath state
  state_t      state_r, next_state_s, step_state_s;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        ack_phase_r;
  logic        co_r, dc_r;
  logic [2:0]  page_r, page_nx;
  logic [6:0]  col_r, col_nx;
  logic [1:0]  mode_r, mode_nx;
  logic        disp_r, disp_nx;
  logic [1:0]  argc_r, argc_nx;
  logic        argm_r, argm_nx;
  logic        busy_r;
  logic        sda_e_r;
  logic        fb_wr_ena_r;
  logic [9:0]  fb_wr_addr_r;
  logic [7:0]  fb_wr_data_r;
  logic        cmd_strobe_r;
  logic [7:0]  cmd_byte_r;

  logic        rx_state_s, ack_state_s;
  logic [7:0]  rx_byte_s;
  logic        byte_done_s, addr_match_s;
  logic        wr_s, cmd_s;

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s = sda_sync_r[SYNC_STAGES-1];

  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // Bus conditions require SCL to have been high on both samples.
  assign start_s = scl_s & scl_prev_r & ~sda_s & sda_prev_r;
  assign stop_s  = scl_s & scl_prev_r & sda_s & ~sda_prev_r;

  assign rx_state_s   = (state_r == S_ADDR) || (state_r == S_CTRL) || (state_r == S_BYTE);
  assign ack_state_s  = (state_r == S_ADDR_ACK) || (state_r == S_CTRL_ACK) ||
                        (state_r == S_BYTE_ACK);
  assign rx_byte_s    = {shift_r[6:0], sda_s};
  assign byte_done_s  = rx_state_s & scl_rise_s & (bit_cnt_r == 3'd7);
  assign addr_match_s = (rx_byte_s == {ADDRESS, 1'b0});

  // Synchronize SCL/SDA into the clock domain; idle bus level is high
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; START/STOP take priority over every state
  always_comb begin
    step_state_s = state_r;
    case (state_r)
      S_IDLE:     step_state_s = S_IDLE;
      S_ADDR: begin
        if (byte_done_s) step_state_s = addr_match_s ? S_ADDR_ACK : S_IGNORE;
        else             step_state_s = S_ADDR;
      end
      S_ADDR_ACK: begin
        if (scl_fall_s && ack_phase_r) step_state_s = S_CTRL;
        else                           step_state_s = S_ADDR_ACK;
      end
      S_CTRL: begin
        if (byte_done_s) step_state_s = S_CTRL_ACK;
        else             step_state_s = S_CTRL;
      end
      S_CTRL_ACK: begin
        if (scl_fall_s && ack_phase_r) step_state_s = S_BYTE;
        else                           step_state_s = S_CTRL_ACK;
      end
      S_BYTE: begin
        if (byte_done_s) step_state_s = S_BYTE_ACK;
        else             step_state_s = S_BYTE;
      end
      S_BYTE_ACK: begin
        // Co=1 allows exactly one byte before the next control byte.
        if (scl_fall_s && ack_phase_r) step_state_s = co_r ? S_CTRL : S_BYTE;
        else                           step_state_s = S_BYTE_ACK;
      end
      S_IGNORE:   step_state_s = S_IGNORE;
      default:    step_state_s = S_IDLE;
    endcase
    if (start_s)     next_state_s = S_ADDR;
    else if (stop_s) next_state_s = S_IDLE;
    else             next_state_s = step_state_s;
  end

  // Byte decode: data pointer advance, command decode and argument skipping
  always_comb begin
    page_nx = page_r;
    col_nx  = col_r;
    mode_nx = mode_r;
    disp_nx = disp_r;
    argc_nx = argc_r;
    argm_nx = argm_r;
    wr_s    = 1'b0;
    cmd_s   = 1'b0;
    if (byte_done_s && (state_r == S_BYTE)) begin
      if (dc_r) begin
        wr_s = 1'b1;
        case (mode_r)
          MODE_HORZ: begin
            col_nx = col_r + 7'd1;
            if (col_r == 7'd127) page_nx = page_r + 3'd1;
            else                 page_nx = page_r;
          end
          MODE_VERT: begin
            page_nx = page_r + 3'd1;
            if (page_r == 3'd7) col_nx = col_r + 7'd1;
            else                col_nx = col_r;
          end
          default: col_nx = col_r + 7'd1;
        endcase
      end else if (argc_r != 2'd0) begin
        // Argument byte: only the addressing-mode argument has an effect.
        cmd_s   = 1'b1;
        argc_nx = argc_r - 2'd1;
        argm_nx = 1'b0;
        if (argm_r && (rx_byte_s[1:0] != 2'b11)) mode_nx = rx_byte_s[1:0];
        else                                     mode_nx = mode_r;
      end else begin
        cmd_s = 1'b1;
        if (rx_byte_s[7:4] == 4'h0) begin
          col_nx = {col_r[6:4], rx_byte_s[3:0]};
        end else if (rx_byte_s[7:3] == 5'b00010) begin
          col_nx = {rx_byte_s[2:0], col_r[3:0]};
        end else if (rx_byte_s[7:3] == 5'b10110) begin
          page_nx = rx_byte_s[2:0];
        end else begin
          case (rx_byte_s)
            8'hAE: disp_nx = 1'b0;
            8'hAF: disp_nx = 1'b1;
            8'h20: begin
              argc_nx = 2'd1;
              argm_nx = 1'b1;
            end
            8'h21, 8'h22: argc_nx = 2'd2;
            8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: argc_nx = 2'd1;
            default: argc_nx = argc_r;
          endcase
        end
      end
    end else begin
      wr_s  = 1'b0;
      cmd_s = 1'b0;
    end
  end

  // Datapath: bit shifting, ACK drive, pointer/mode registers and output strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'd0;
      ack_phase_r  <= 1'b0;
      co_r         <= 1'b0;
      dc_r         <= 1'b0;
      page_r       <= 3'd0;
      col_r        <= 7'd0;
      mode_r       <= MODE_PAGE;
      disp_r       <= 1'b0;
      argc_r       <= 2'd0;
      argm_r       <= 1'b0;
      busy_r       <= 1'b0;
      sda_e_r      <= 1'b0;
      fb_wr_ena_r  <= 1'b0;
      fb_wr_addr_r <= 10'd0;
      fb_wr_data_r <= 8'd0;
      cmd_strobe_r <= 1'b0;
      cmd_byte_r   <= 8'd0;
    end else begin
      page_r       <= page_nx;
      col_r        <= col_nx;
      mode_r       <= mode_nx;
      disp_r       <= disp_nx;
      fb_wr_ena_r  <= wr_s;
      cmd_strobe_r <= cmd_s;
      if (wr_s) begin
        fb_wr_addr_r <= {page_r, col_r};
        fb_wr_data_r <= rx_byte_s;
      end
      if (cmd_s) begin
        cmd_byte_r <= rx_byte_s;
      end
      if (start_s || stop_s) begin
        // Bus condition: drop any partial byte, release SDA, clear arguments.
        bit_cnt_r   <= 3'd0;
        ack_phase_r <= 1'b0;
        sda_e_r     <= 1'b0;
        argc_r      <= 2'd0;
        argm_r      <= 1'b0;
        if (stop_s) busy_r <= 1'b0;
      end else begin
        argc_r <= argc_nx;
        argm_r <= argm_nx;
        if (rx_state_s && scl_rise_s) begin
          shift_r   <= rx_byte_s;
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        if (byte_done_s && (state_r == S_ADDR) && addr_match_s) begin
          busy_r <= 1'b1;
        end
        if (byte_done_s && (state_r == S_CTRL)) begin
          co_r <= rx_byte_s[7];
          dc_r <= rx_byte_s[6];
        end
        // First SCL fall in an ACK state pulls SDA, the second releases it.
        if (ack_state_s && scl_fall_s) begin
          ack_phase_r <= ~ack_phase_r;
          sda_e_r     <= ~ack_phase_r;
        end
      end
    end
  end

  assign sda_o      = 1'b0;
  assign sda_e      = sda_e_r;
  assign fb_wr_ena  = fb_wr_ena_r;
  assign fb_wr_addr = fb_wr_addr_r;
  assign fb_wr_data = fb_wr_data_r;
  assign cmd_strobe = cmd_strobe_r;
  assign cmd_byte   = cmd_byte_r;
  assign display_on = disp_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ssd1306_i2c_target.sv
// Testbench for ssd1306_i2c_target: bench-driven I2C master, byte-level
// reference model with expected-strobe queues, and a per-cycle compare process.

module tb_ssd1306_i2c_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_o, sda_e;
  logic       fb_wr_ena;
  logic [9:0] fb_wr_addr;
  logic [7:0] fb_wr_data;
  logic       cmd_strobe;
  logic [7:0] cmd_byte;
  logic       display_on;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Open-drain wired-AND of master and target
  assign sda_line = sda_m & ~(sda_e & ~sda_o);

  ssd1306_i2c_target #(.ADDRESS(7'h3C), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .sda_e      (sda_e),
    .fb_wr_ena  (fb_wr_ena),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .cmd_strobe (cmd_strobe),
    .cmd_byte   (cmd_byte),
    .display_on (display_on),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (byte level) ----------------
  int   m_page, m_col, m_mode, m_args, m_ph;
  logic m_disp, m_busy, m_argmode, m_co, m_dc;
  logic [17:0] exp_wr_q[$];   // {addr, data}
  logic [8:0]  exp_cmd_q[$];  // {display_on after the command, byte}
  logic [17:0] wr_hist[$];
  logic [7:0]  tx_q[$];
  int sda_e_cycles = 0;
  int obs_wr_n = 0;
  int obs_cmd_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_page = 0; m_col = 0; m_mode = 2; m_disp = 1'b0; m_busy = 1'b0;
    m_args = 0; m_argmode = 1'b0; m_ph = 3; m_co = 1'b0; m_dc = 1'b0;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    if (m_args > 0) begin
      m_args--;
      if (m_argmode) begin
        m_argmode = 1'b0;
        if (b[1:0] != 2'b11) m_mode = int'(b[1:0]);
      end
    end else if (b <= 8'h0F) m_col = (m_col / 16) * 16 + int'(b[3:0]);
    else if (b >= 8'h10 && b <= 8'h17) m_col = int'(b - 8'h10) * 16 + m_col % 16;
    else if (b >= 8'hB0 && b <= 8'hB7) m_page = int'(b - 8'hB0);
    else if (b == 8'hAE) m_disp = 1'b0;
    else if (b == 8'hAF) m_disp = 1'b1;
    else if (b == 8'h20) begin m_args = 1; m_argmode = 1'b1; end
    else if (b == 8'h21 || b == 8'h22) m_args = 2;
    else if (b inside {8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB}) m_args = 1;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic ack);
    int lin;
    ack = 1'b0;
    case (m_ph)
      0: begin
        if (b == 8'h78) begin ack = 1'b1; m_busy = 1'b1; m_ph = 1; end
        else m_ph = 3;
      end
      1: begin ack = 1'b1; m_co = b[7]; m_dc = b[6]; m_ph = 2; end
      2: begin
        ack = 1'b1;
        if (m_dc) begin
          exp_wr_q.push_back({10'(m_page * 128 + m_col), b});
          case (m_mode)
            0: begin
              lin = (m_page * 128 + m_col + 1) % 1024;
              m_page = lin / 128; m_col = lin % 128;
            end
            1: begin
              lin = (m_col * 8 + m_page + 1) % 1024;
              m_col = lin / 8; m_page = lin % 8;
            end
            default: m_col = (m_col + 1) % 128;
          endcase
        end else begin
          model_cmd(b);
          exp_cmd_q.push_back({m_disp, b});
        end
        m_ph = m_co ? 1 : 2;
      end
      default: ack = 1'b0;
    endcase
  endtask

  // ---------------- compare process ----------------
  // Every strobe must match the next expected entry from the model.
  always @(negedge clk) begin
    logic [17:0] ew;
    logic [8:0]  ec;
    if (!reset) begin
      if (sda_e) sda_e_cycles++;
      if (fb_wr_ena) begin
        obs_wr_n++;
        wr_hist.push_back({fb_wr_addr, fb_wr_data});
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL fb_write: got unexpected write addr %0d data 0x%0h, expected none",
                   fb_wr_addr, fb_wr_data);
        end else begin
          ew = exp_wr_q.pop_front();
          check("fb_write", 32'({fb_wr_addr, fb_wr_data}), 32'(ew));
        end
      end
      if (cmd_strobe) begin
        obs_cmd_n++;
        if (exp_cmd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL cmd_strobe: got unexpected byte 0x%0h, expected none", cmd_byte);
        end else begin
          ec = exp_cmd_q.pop_front();
          check("cmd_strobe", 32'({display_on, cmd_byte}), 32'(ec));
        end
      end
    end
  end

  // ---------------- bus master ----------------
  task automatic bit_out(input logic b);
    repeat (4) @(posedge clk); #1 sda_m = b;
    repeat (4) @(posedge clk); #1 scl = 1'b1;
    repeat (8) @(posedge clk); #1 scl = 1'b0;
  endtask

  task automatic start_cond();
    #1 sda_m = 1'b0;
    repeat (8) @(posedge clk); #1 scl = 1'b0;
  endtask

  task automatic stop_cond();
    repeat (4) @(posedge clk); #1 sda_m = 1'b0;
    repeat (4) @(posedge clk); #1 scl = 1'b1;
    repeat (8) @(posedge clk); #1 sda_m = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic exp_ack, got_ack;
    model_byte(b, exp_ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    repeat (4) @(posedge clk); #1 sda_m = 1'b1;
    repeat (4) @(posedge clk); #1 scl = 1'b1;
    repeat (4) @(posedge clk); #1;
    got_ack = ~sda_line;
    check("ack", 32'(got_ack), 32'(exp_ack));
    check("busy_in_xfer", 32'(busy), 32'(m_busy));
    check("strobes_drained", 32'(exp_wr_q.size() + exp_cmd_q.size()), 32'd0);
    repeat (4) @(posedge clk); #1 scl = 1'b0;
  endtask

  task automatic open_xfer();
    m_ph = 0; m_args = 0; m_argmode = 1'b0;
    start_cond();
  endtask

  task automatic close_xfer();
    stop_cond();
    m_busy = 1'b0; m_args = 0; m_argmode = 1'b0; m_ph = 3;
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic run_xfer();
    open_xfer();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    close_xfer();
  endtask

  logic [7:0] init_bytes [0:34] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07,
    8'h2E, 8'hA4, 8'hA6, 8'hE3, 8'hAF};
  int init_len [0:16] = '{1, 2, 2, 2, 1, 2, 2, 1, 1, 2, 2, 2, 2, 2, 3, 3, 5};
  logic [7:0] cmd_tab [0:15] = '{8'h00, 8'h07, 8'h0F, 8'h10, 8'h15, 8'h17, 8'hB0, 8'hB5,
    8'hB7, 8'hAE, 8'hAF, 8'h20, 8'h21, 8'h22, 8'h81, 8'hDA};

  // Watchdog: the run is a fixed number of bus cycles
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int base_cmd, base_wr, base_sdae, k, r, n;
    reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
    model_reset();
    repeat (4) @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_sda", 32'({sda_e, sda_o}), 32'd0);
    check("rst_fb", 32'({fb_wr_ena, fb_wr_addr, fb_wr_data}), 32'd0);
    check("rst_cmd", 32'({cmd_strobe, cmd_byte}), 32'd0);
    check("rst_disp_busy", 32'({display_on, busy}), 32'd0);

    // Pointer to page 5 column 0x35 before the init sequence
    tx_q = '{8'h78, 8'h00, 8'hB5, 8'h05, 8'h13}; run_xfer();

    // Controller init sequence: 17 transfers, 35 command bytes
    base_cmd = obs_cmd_n; base_wr = obs_wr_n; k = 0;
    for (int t = 0; t < 17; t++) begin
      tx_q = '{8'h78, 8'h00};
      for (int j = 0; j < init_len[t]; j++) begin tx_q.push_back(init_bytes[k]); k++; end
      run_xfer();
    end
    check("init_cmd_count", 32'(obs_cmd_n - base_cmd), 32'd35);
    check("init_wr_count", 32'(obs_wr_n - base_wr), 32'd0);
    check("init_display_on", 32'(display_on), 32'd1);
    check("init_model_mode", 32'(m_mode), 32'd0);
    check("init_model_ptr", 32'(m_page * 128 + m_col), 32'd693);
    tx_q = '{8'h78, 8'h40, 8'h5A}; run_xfer();
    check("init_ptr_write", 32'(wr_hist[$]), {14'd0, 10'd693, 8'h5A});

    // Page mode, pointer page 2 column 0x35
    tx_q = '{8'h78, 8'h00, 8'h20, 8'h02}; run_xfer();
    tx_q = '{8'h78, 8'h00, 8'h00, 8'hB2, 8'h05, 8'h13}; run_xfer();
    tx_q = '{8'h78, 8'h40, 8'hAA, 8'h55}; run_xfer();
    check("page_wr0", 32'(wr_hist[$-1]), {14'd0, 10'd309, 8'hAA});
    check("page_wr1", 32'(wr_hist[$]), {14'd0, 10'd310, 8'h55});

    // STOP in the middle of a byte; argument counter must clear
    open_xfer();
    send_byte(8'h78); send_byte(8'h00); send_byte(8'h21);
    for (int i = 7; i >= 3; i--) bit_out(1'b1);
    close_xfer();
    tx_q = '{8'h78, 8'h00, 8'hAE}; run_xfer();
    check("stop_clears_args", 32'(display_on), 32'd0);

    // Horizontal mode wrap 1023 -> 0
    tx_q = '{8'h78, 8'h00, 8'h20, 8'h00, 8'hB7, 8'h0F, 8'h17}; run_xfer();
    tx_q = '{8'h78, 8'h40, 8'h11, 8'h22}; run_xfer();
    check("horz_wr0", 32'(wr_hist[$-1]), {14'd0, 10'd1023, 8'h11});
    check("horz_wr1", 32'(wr_hist[$]), {14'd0, 10'd0, 8'h22});

    // Wrong address and read bit: no ACK, no strobes
    base_cmd = obs_cmd_n; base_wr = obs_wr_n; base_sdae = sda_e_cycles;
    tx_q = '{8'h7A, 8'h00, 8'hAF}; run_xfer();
    tx_q = '{8'h79, 8'h00, 8'hAF}; run_xfer();
    check("nack_sda_e", 32'(sda_e_cycles - base_sdae), 32'd0);
    check("nack_strobes", 32'(obs_cmd_n - base_cmd + obs_wr_n - base_wr), 32'd0);

    // Co=1 single-byte control
    tx_q = '{8'h78, 8'h00, 8'h00, 8'h10}; run_xfer();
    tx_q = '{8'h78, 8'h80, 8'hB3, 8'hC0, 8'h77}; run_xfer();
    check("co1_write", 32'(wr_hist[$]), {14'd0, 10'd384, 8'h77});

    // Reset during the 4th data bit
    base_wr = obs_wr_n;
    open_xfer();
    send_byte(8'h78); send_byte(8'h40);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    repeat (4) @(posedge clk); #1 sda_m = 1'b1;
    repeat (4) @(posedge clk); #1 scl = 1'b1;
    repeat (3) @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_mid_sda_e", 32'(sda_e), 32'd0);
    check("rst_mid_busy_disp", 32'({busy, display_on}), 32'd0);
    repeat (4) @(posedge clk); #1 scl = 1'b0;
    stop_cond();
    check("rst_mid_no_write", 32'(obs_wr_n - base_wr), 32'd0);
    tx_q = '{8'h78, 8'h40, 8'h99}; run_xfer();
    check("after_rst_write", 32'(wr_hist[$]), {14'd0, 10'd0, 8'h99});

    // Randomized transfers against the model
    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(0, 9);
      tx_q = '{(r == 0) ? 8'h7A : ((r == 1) ? 8'h79 : 8'h78)};
      tx_q.push_back(8'($urandom));
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 1) == 1) tx_q.push_back(cmd_tab[$urandom_range(0, 15)]);
        else                           tx_q.push_back(8'($urandom));
      end
      run_xfer();
    end

    check("final_queues_empty", 32'(exp_wr_q.size() + exp_cmd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
